// File: rtl/stream_max_min_pkg.sv
// rtl/stream_max_min_pkg.sv - shared types for the serial max/min frame tracker
package stream_max_min_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

endpackage

// File: rtl/stream_max_min_update.sv
// rtl/stream_max_min_update.sv - combinational compare/select cell for running extrema
module max_min_update #(
    parameter int WIDTH = 8,
    parameter int IDXW  = 3
) (
    input  logic [WIDTH-1:0] cur_max,
    input  logic [WIDTH-1:0] cur_min,
    input  logic [IDXW-1:0]  cur_max_idx,
    input  logic [IDXW-1:0]  cur_min_idx,
    input  logic [WIDTH-1:0] in_data,
    input  logic [IDXW-1:0]  count,
    input  logic             first,
    output logic [WIDTH-1:0] nxt_max,
    output logic [WIDTH-1:0] nxt_min,
    output logic [IDXW-1:0]  nxt_max_idx,
    output logic [IDXW-1:0]  nxt_min_idx
);

    always_comb begin
        nxt_max     = cur_max;
        nxt_min     = cur_min;
        nxt_max_idx = cur_max_idx;
        nxt_min_idx = cur_min_idx;
        if (first) begin
            nxt_max     = in_data;
            nxt_min     = in_data;
            nxt_max_idx = '0;
            nxt_min_idx = '0;
        end else begin
            // Strict compares so ties keep the earliest index.
            if (in_data > cur_max) begin
                nxt_max     = in_data;
                nxt_max_idx = count;
            end
            if (in_data < cur_min) begin
                nxt_min     = in_data;
                nxt_min_idx = count;
            end
        end
    end

endmodule

// File: rtl/stream_max_min.sv
// rtl/stream_max_min.sv - per-frame max/min with indices over a serial sample stream
module stream_max_min
    import stream_max_min_pkg::*;
#(
    parameter int  N     = 5,
    parameter int  WIDTH = 8,
    localparam int IDXW  = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] min_val,
    output logic [IDXW-1:0]  max_idx,
    output logic [IDXW-1:0]  min_idx
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    state_t            state;
    state_t            next_state;
    logic [IDXW-1:0]   count;
    logic              accept;
    logic              last_sample;
    logic [WIDTH-1:0]  nxt_max;
    logic [WIDTH-1:0]  nxt_min;
    logic [IDXW-1:0]   nxt_max_idx;
    logic [IDXW-1:0]   nxt_min_idx;

    assign in_ready    = (state == ACCUM);
    assign out_valid   = (state == DONE);
    assign accept      = in_valid && in_ready;
    assign last_sample = (count == LAST_IDX);

    max_min_update #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_update (
        .cur_max     (max_val),
        .cur_min     (min_val),
        .cur_max_idx (max_idx),
        .cur_min_idx (min_idx),
        .in_data     (in_data),
        .count       (count),
        .first       (count == '0),
        .nxt_max     (nxt_max),
        .nxt_min     (nxt_min),
        .nxt_max_idx (nxt_max_idx),
        .nxt_min_idx (nxt_min_idx)
    );

    always_comb begin
        next_state = state;
        case (state)
            ACCUM:   if (accept && last_sample) next_state = DONE;
            DONE:    if (out_ready)             next_state = ACCUM;
            default: next_state = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= next_state;
        end
    end

    // Wrap is forced at N-1 so non-power-of-two frame lengths work.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (accept) begin
            count <= last_sample ? '0 : count + IDXW'(1);
        end
    end

    // Results hold through the handoff until sample 0 of the next frame lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_val <= '0;
            min_val <= '0;
            max_idx <= '0;
            min_idx <= '0;
        end else if (accept) begin
            max_val <= nxt_max;
            min_val <= nxt_min;
            max_idx <= nxt_max_idx;
            min_idx <= nxt_min_idx;
        end
    end

endmodule

// File: tb/tb_stream_max_min.sv
// tb/tb_stream_max_min.sv - scoreboard bench for stream_max_min with directed frames
module tb_stream_max_min;

    typedef struct {
        int mx;
        int mn;
        int mxi;
        int mni;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] max_val;
    logic [7:0] min_val;
    logic [2:0] max_idx;
    logic [2:0] min_idx;

    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;
    exp_t sb[$];
    int   hs_cyc[$];
    int   last_hs = -10;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stream_max_min #(.N(5), .WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .max_val   (max_val),
        .min_val   (min_val),
        .max_idx   (max_idx),
        .min_idx   (min_idx)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    task automatic push_exp(input int mx, input int mn, input int mxi, input int mni);
        exp_t e;
        e.mx = mx; e.mn = mn; e.mxi = mxi; e.mni = mni;
        sb.push_back(e);
    endtask

    // Called at posedge+1; sample is accepted on the edge after in_ready is seen high.
    task automatic send(input logic [7:0] d);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) check("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                              input logic [7:0] s3, input logic [7:0] s4, input bit gapped);
        logic [7:0] s [5];
        s = '{s0, s1, s2, s3, s4};
        for (int i = 0; i < 5; i++) begin
            send(s[i]);
            if (gapped) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: each negedge with out_valid && out_ready is one result handoff.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && last_hs == cyc - 1) check("out_valid_one_cycle", 1, 0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("max_val", int'(max_val), e.mx);
                    check("min_val", int'(min_val), e.mn);
                    check("max_idx", int'(max_idx), e.mxi);
                    check("min_idx", int'(min_idx), e.mni);
                end
                hs_cyc.push_back(cyc);
                last_hs = cyc;
            end
        end
    end

    initial begin
        int t;
        #2;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_max_val", int'(max_val), 0);
        check("rst_min_idx", int'(min_idx), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);

        // Back-to-back frames with out_ready high: 6-cycle period.
        push_exp(9, 1, 1, 2);
        send_frame(8'd3, 8'd9, 8'd1, 8'd9, 8'd4, 1'b0);
        push_exp(7, 7, 0, 0);
        send_frame(8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 1'b0);
        idle(2);
        if (hs_cyc.size() >= 2) check("frame_period", hs_cyc[1] - hs_cyc[0], 6);
        else check("frame_period_seen", hs_cyc.size(), 2);

        // Backpressure: hold result for 10 cycles, ignore input pulses.
        out_ready = 1'b0;
        push_exp(255, 0, 0, 1);
        send_frame(8'd255, 8'd0, 8'd128, 8'd0, 8'd255, 1'b0);
        t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("bp_out_valid_rise", int'(out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_data  = 8'd200;
            @(negedge clk);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_max_val", int'(max_val), 255);
            check("bp_min_val", int'(min_val), 0);
            check("bp_max_idx", int'(max_idx), 0);
            check("bp_min_idx", int'(min_idx), 1);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(2);

        // Gapped frame, then result hold after handoff.
        push_exp(8, 2, 2, 1);
        send_frame(8'd5, 8'd2, 8'd8, 8'd6, 8'd3, 1'b1);
        idle(3);
        check("hold_max_val", int'(max_val), 8);
        check("hold_min_idx", int'(min_idx), 1);
        check("hold_in_ready", int'(in_ready), 1);

        // Reset mid-frame discards the partial frame.
        send(8'd1);
        send(8'd2);
        send(8'd3);
        rst = 1'b1;
        #1;
        check("mid_rst_max_val", int'(max_val), 0);
        check("mid_rst_min_val", int'(min_val), 0);
        check("mid_rst_max_idx", int'(max_idx), 0);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);
        push_exp(9, 0, 3, 4);
        send_frame(8'd4, 8'd6, 8'd5, 8'd9, 8'd0, 1'b0);

        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("scoreboard_drained", sb.size(), 0);
        idle(2);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/stream_max_min.md
# stream_max_min

Serial-input companion to the parallel max/min finder: accepts a frame of exactly N unsigned WIDTH-bit samples one per handshake, tracks running maximum and minimum with the index of each, then presents the result on a valid/ready output port. Sits between a sample-streaming producer (ADC/FIFO side) and consumers that only need per-frame extrema, avoiding a full N-wide array bus.

## Interface
- N, 5: samples per frame; legal range N ≥ 2
- WIDTH, 8: sample width, unsigned
- IDXW, $clog2(N): index width (derived, not overridden)
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  sample present
- in_ready  out  1  block can accept a sample
- in_data  in  WIDTH  sample value
- out_valid  out  1  frame result available
- out_ready  in  1  consumer takes result
- max_val  out  WIDTH  largest sample of frame
- min_val  out  WIDTH  smallest sample of frame
- max_idx  out  IDXW  position (0..N-1) of max_val
- min_idx  out  IDXW  position (0..N-1) of min_val

## Operation
- Two states: ACCUM, DONE. Reset state ACCUM.
- Reset values: state ACCUM, count 0, out_valid 0, max_val/min_val/max_idx/min_idx all 0. in_ready = (state==ACCUM), so reads 1 during and after reset; inputs are ignored while rst is high.
- Accept = in_valid && in_ready, sampled at rising clk.
- ACCUM, accept at count 0: max_val=min_val=in_data, max_idx=min_idx=0.
- ACCUM, accept at count k>0: if in_data > max_val (strict, unsigned) → max_val=in_data, max_idx=k; if in_data < min_val (strict) → min_val=in_data, min_idx=k. Ties keep the earliest index. Both may update on the same sample only at k=0.
- Count increments per accept; on accept at count N-1: count→0, state→DONE, out_valid→1.
- in_valid low in ACCUM: nothing changes; gaps between samples are allowed without limit.
- DONE: in_ready=0; out_valid=1 and all four result outputs held stable until out_ready=1. On out_valid && out_ready: out_valid→0, state→ACCUM.
- Result registers keep the last frame's values after handoff until sample 0 of the next frame is accepted.
- Async reset mid-frame or in DONE: partial frame discarded, all outputs to reset values immediately; next accepted sample is index 0.

## Timing
- out_valid rises on the clk edge that accepts sample N-1 (visible the cycle after the last in handshake).
- Earliest next-frame accept: the cycle after the out handshake (in_ready rises on the same edge that clears out_valid).
- Max throughput: one frame per N+1 cycles with out_ready held high.
- No combinational path from in_* to out_*; in_ready depends only on state (registered), never on out_ready.
- Result outputs are driven straight from registers.

## Structure
- Package stream_max_min_pkg: state typedef (ACCUM, DONE).
- One sub-module natural: max_min_update — combinational compare/select cell taking current max/min/indices, in_data, count, first flag; returns next values. Top block holds FSM, counter, registers.
- Counter is IDXW bits; wrap forced at N-1, not by overflow (N need not be a power of two).

## Test plan
- Frame 3,9,1,9,4 (N=5, WIDTH=8), in_valid always high, out_ready high → max_val=9 max_idx=1, min_val=1 min_idx=2; out_valid for one cycle; 6-cycle frame period.
- All-equal frame 7,7,7,7,7 → max_val=min_val=7, both indices 0.
- Frame 255,0,128,0,255 → max 255 idx 0, min 0 idx 1 (unsigned compare, earliest tie).
- Backpressure: out_ready low 10 cycles after frame done → out_valid and results stable, in_ready=0, in_valid pulses ignored; next frame starts only after handshake.
- Gapped input: in_valid toggled every other cycle over frame 5,2,8,6,3 → max 8 idx 2, min 2 idx 1.
- rst pulse after 3 samples of 1,2,3 → outputs zero immediately; following frame 4,6,5,9,0 → max 9 idx 3, min 0 idx 4.
